// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and constants for the pipeline hazard/bypass controller.
package pipe_pkg;

    // Register index width shared by every block that handles tags.
    localparam int REG_BITS = 5;

    // Tracked stage indices after decode.
    localparam int STG_X = 0;
    localparam int STG_M = 1;
    localparam int STG_W = 2;

    // Forward-select encodings: 0 reads the register file, k forwards from stage k-1.
    localparam int FWD_RF = 0;
    localparam int FWD_X  = 1;
    localparam int FWD_M  = 2;
    localparam int FWD_W  = 3;

    // One in-flight destination write travelling down the pipeline.
    typedef struct packed {
        logic                valid;
        logic [REG_BITS-1:0] tag;
        logic                is_load;
    } stage_t;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode-side handshake between the decoder and the hazard scoreboard.
interface hazard_scoreboard_if #(
    parameter int SEL_W = 2
) ();
    import pipe_pkg::*;

    logic                dec_valid;
    logic [REG_BITS-1:0] dec_rs;
    logic [REG_BITS-1:0] dec_rt;
    logic                dec_rs_used;
    logic                dec_rt_used;
    logic [REG_BITS-1:0] dec_rd;
    logic                dec_rd_we;
    logic                dec_is_load;
    logic                dec_is_long;
    logic                flush;
    logic                long_done;
    logic                stall;
    logic [SEL_W-1:0]    fwd_sel_a;
    logic [SEL_W-1:0]    fwd_sel_b;
    logic                long_busy;

    // Decoder side: presents the decode slot, receives stall and bypass selects.
    modport master (
        output dec_valid, dec_rs, dec_rt, dec_rs_used, dec_rt_used,
        output dec_rd, dec_rd_we, dec_is_load, dec_is_long, flush, long_done,
        input  stall, fwd_sel_a, fwd_sel_b, long_busy
    );

    // Scoreboard side.
    modport slave (
        input  dec_valid, dec_rs, dec_rt, dec_rs_used, dec_rt_used,
        input  dec_rd, dec_rd_we, dec_is_load, dec_is_long, flush, long_done,
        output stall, fwd_sel_a, fwd_sel_b, long_busy
    );

endinterface

// File: rtl/hazard_scoreboard_src_match_prio.sv
// Priority match of one source operand against the tracked destination stages.
// The youngest matching stage supplies the bypass; a load there that is not yet
// forwardable is flagged as a load-use hazard.
module src_match_prio
    import pipe_pkg::*;
#(
    parameter int STAGES           = 3,
    parameter int LOAD_READY_STAGE = 2,
    parameter int SEL_W            = 2
) (
    input  logic                used,
    input  logic [REG_BITS-1:0] src,
    input  stage_t              stages [STAGES],
    output logic [SEL_W-1:0]    fwd_sel,
    output logic                load_haz
);

    logic [STAGES-1:0] hit;

    // Register 0 is hard-wired, so it never matches an in-flight write.
    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_hit
            assign hit[gi] = used && (src != '0) && stages[gi].valid
                             && (stages[gi].tag == src);
        end
    endgenerate

    // Scan oldest to youngest so the youngest hit overwrites older ones.
    always_comb begin
        fwd_sel  = '0;
        load_haz = 1'b0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            if (hit[i]) begin
                fwd_sel  = SEL_W'(i + 1);
                load_haz = stages[i].is_load && (i < LOAD_READY_STAGE);
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard and bypass controller: tracks destinations in flight after decode,
// produces operand bypass selects, and stalls decode on load-use, long-op
// RAW/WAW and long-unit structural hazards. Tag width comes from pipe_pkg.
module hazard_scoreboard
    import pipe_pkg::*;
#(
    parameter int STAGES           = 3,
    parameter int LOAD_READY_STAGE = 2,
    parameter int SEL_W            = 2
) (
    input  logic                clock,
    input  logic                reset,
    hazard_scoreboard_if.slave  bus
);

    stage_t              stage_reg [STAGES];
    logic                pend_valid_reg;
    logic [REG_BITS-1:0] pend_tag_reg;

    logic [SEL_W-1:0] sel_a;
    logic [SEL_W-1:0] sel_b;
    logic             load_haz_a;
    logic             load_haz_b;

    logic active;
    logic raw_long;
    logic waw_long;
    logic struct_haz;
    logic stall_int;
    logic accept;
    logic entry_valid;
    logic long_accept;

    src_match_prio #(
        .STAGES           (STAGES),
        .LOAD_READY_STAGE (LOAD_READY_STAGE),
        .SEL_W            (SEL_W)
    ) u_match_a (
        .used     (bus.dec_rs_used),
        .src      (bus.dec_rs),
        .stages   (stage_reg),
        .fwd_sel  (sel_a),
        .load_haz (load_haz_a)
    );

    src_match_prio #(
        .STAGES           (STAGES),
        .LOAD_READY_STAGE (LOAD_READY_STAGE),
        .SEL_W            (SEL_W)
    ) u_match_b (
        .used     (bus.dec_rt_used),
        .src      (bus.dec_rt),
        .stages   (stage_reg),
        .fwd_sel  (sel_b),
        .load_haz (load_haz_b)
    );

    // Hazard terms; a pending tag is never 0, so no explicit r0 guard is needed.
    // long_done deliberately does not clear RAW/WAW this cycle: the result lands
    // in the register file at the edge, and the consumer reads it next cycle.
    always_comb begin
        active      = bus.dec_valid & ~bus.flush;
        raw_long    = pend_valid_reg
                      & ((bus.dec_rs_used & (bus.dec_rs == pend_tag_reg))
                       | (bus.dec_rt_used & (bus.dec_rt == pend_tag_reg)));
        waw_long    = pend_valid_reg & bus.dec_rd_we & (bus.dec_rd == pend_tag_reg);
        struct_haz  = bus.dec_is_long & pend_valid_reg & ~bus.long_done;
        stall_int   = active & (load_haz_a | load_haz_b | raw_long | waw_long | struct_haz);
        accept      = active & ~stall_int;
        entry_valid = accept & bus.dec_rd_we & (bus.dec_rd != '0) & ~bus.dec_is_long;
        long_accept = accept & bus.dec_is_long & (bus.dec_rd != '0);
    end

    assign bus.stall     = stall_int;
    assign bus.fwd_sel_a = active ? sel_a : '0;
    assign bus.fwd_sel_b = active ? sel_b : '0;
    assign bus.long_busy = pend_valid_reg;

    // Destination pipeline shifts every cycle; a stalled or killed slot enters as a bubble.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_reg[i] <= '0;
            end
        end else begin
            stage_reg[0].valid   <= entry_valid;
            stage_reg[0].tag     <= bus.dec_rd;
            stage_reg[0].is_load <= bus.dec_is_load;
            for (int i = 1; i < STAGES; i++) begin
                stage_reg[i] <= stage_reg[i-1];
            end
        end
    end

    // Long-op pending tag; a newly accepted long op wins over a same-cycle completion.
    always_ff @(posedge clock) begin
        if (reset) begin
            pend_valid_reg <= 1'b0;
            pend_tag_reg   <= '0;
        end else if (long_accept) begin
            pend_valid_reg <= 1'b1;
            pend_tag_reg   <= bus.dec_rd;
        end else if (bus.long_done) begin
            pend_valid_reg <= 1'b0;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench: stimulus pushes expected outputs from a behavioural model,
// a monitor on the falling edge pops and compares them against the DUT.
module tb_hazard_scoreboard;
    localparam int STAGES = 3;
    localparam int LRS    = 2;
    localparam int SEL_W  = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    hazard_scoreboard_if #(.SEL_W(SEL_W)) bus ();

    hazard_scoreboard #(
        .STAGES           (STAGES),
        .LOAD_READY_STAGE (LRS),
        .SEL_W            (SEL_W)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        bit v;
        int tag;
        bit ld;
    } ent_t;

    typedef struct {
        string name;
        bit    st;
        int    fa;
        int    fb;
        bit    busy;
    } exp_t;

    // Model state: list of recent writers (index 0 = youngest) and the long-op tag.
    ent_t hist[$];
    bit   pv;
    int   ptag;
    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic int sel_of(int src, bit used);
        if (!used || src == 0) return 0;
        for (int i = 0; i < hist.size(); i++)
            if (hist[i].v && hist[i].tag == src) return i + 1;
        return 0;
    endfunction

    function automatic bit load_use(int src, bit used);
        int s;
        s = sel_of(src, used);
        return (s != 0) && hist[s-1].ld && ((s - 1) < LRS);
    endfunction

    task automatic model_clear();
        hist.delete();
        for (int i = 0; i < STAGES; i++) hist.push_back('{v: 1'b0, tag: 0, ld: 1'b0});
        pv   = 1'b0;
        ptag = 0;
    endtask

    task automatic cmp(string name, string field, int act, int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s.%s: got %0d, expected %0d", name, field, act, expv);
        end
    endtask

    // Monitor: compares whatever the DUT presents mid-cycle against the queued expectation.
    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            cmp(e.name, "stall", int'(bus.stall), int'(e.st));
            cmp(e.name, "fwd_sel_a", int'(bus.fwd_sel_a), e.fa);
            cmp(e.name, "fwd_sel_b", int'(bus.fwd_sel_b), e.fb);
            cmp(e.name, "long_busy", int'(bus.long_busy), int'(e.busy));
            $display("txn %-12s stall=%0d sel_a=%0d sel_b=%0d busy=%0d", e.name,
                     bus.stall, bus.fwd_sel_a, bus.fwd_sel_b, bus.long_busy);
        end
    end

    // One decode cycle: drive, predict, advance the clock, update the model.
    task automatic step(string name, bit v, int rs, bit rsu, int rt, bit rtu,
                        int rd, bit we, bit ld, bit lng, bit fl, bit done);
        bit   active, st, ent_v;
        exp_t e;
        bus.dec_valid   = v;
        bus.dec_rs      = 5'(rs);
        bus.dec_rs_used = rsu;
        bus.dec_rt      = 5'(rt);
        bus.dec_rt_used = rtu;
        bus.dec_rd      = 5'(rd);
        bus.dec_rd_we   = we;
        bus.dec_is_load = ld;
        bus.dec_is_long = lng;
        bus.flush       = fl;
        bus.long_done   = done;
        active = v && !fl;
        st = active && (load_use(rs, rsu) || load_use(rt, rtu)
                        || (pv && ((rsu && rs == ptag) || (rtu && rt == ptag)))
                        || (pv && we && rd == ptag)
                        || (lng && pv && !done));
        e.name = name;
        e.st   = st;
        e.fa   = active ? sel_of(rs, rsu) : 0;
        e.fb   = active ? sel_of(rt, rtu) : 0;
        e.busy = pv;
        exp_q.push_back(e);
        @(posedge clock);
        ent_v = active && !st && we && rd != 0 && !lng;
        hist.push_front('{v: ent_v, tag: rd, ld: ld});
        void'(hist.pop_back());
        if (active && !st && lng && rd != 0) begin
            pv   = 1'b1;
            ptag = rd;
        end else if (done) begin
            pv = 1'b0;
        end
        #1;
    endtask

    task automatic do_reset();
        bus.dec_valid = 1'b0;
        bus.flush     = 1'b0;
        bus.long_done = 1'b0;
        reset = 1'b1;
        @(posedge clock);
        @(posedge clock);
        model_clear();
        #1;
        reset = 1'b0;
    endtask

    initial begin
        bus.dec_valid = 0; bus.dec_rs = 0; bus.dec_rt = 0; bus.dec_rs_used = 0;
        bus.dec_rt_used = 0; bus.dec_rd = 0; bus.dec_rd_we = 0; bus.dec_is_load = 0;
        bus.dec_is_long = 0; bus.flush = 0; bus.long_done = 0;
        model_clear();
        do_reset();
        //    name           v  rs rsu rt rtu rd we ld lng fl done
        step("reset_idle",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // ALU forwarding from X then M
        step("add_r3",       1, 1, 1, 2, 1, 3, 1, 0, 0, 0, 0);
        step("fwd_x",        1, 3, 1, 1, 1, 4, 1, 0, 0, 0, 0);
        step("fwd_m",        1, 3, 1, 1, 1, 4, 1, 0, 0, 0, 0);
        // Load-use: two stall cycles then forward from W
        step("lw_r5",        1, 2, 1, 0, 0, 5, 1, 1, 0, 0, 0);
        step("lu_x",         1, 5, 1, 5, 1, 6, 1, 0, 0, 0, 0);
        step("lu_m",         1, 5, 1, 5, 1, 6, 1, 0, 0, 0, 0);
        step("lu_w",         1, 5, 1, 5, 1, 6, 1, 0, 0, 0, 0);
        // Long op RAW held through the done cycle
        step("mul_r7",       1, 1, 1, 2, 1, 7, 1, 0, 1, 0, 0);
        step("raw_wait",     1, 7, 1, 0, 1, 8, 1, 0, 0, 0, 0);
        step("raw_wait2",    1, 7, 1, 0, 1, 8, 1, 0, 0, 0, 0);
        step("raw_done",     1, 7, 1, 0, 1, 8, 1, 0, 0, 0, 1);
        step("raw_issue",    1, 7, 1, 0, 1, 8, 1, 0, 0, 0, 0);
        // Structural: second long op waits, issues in the done cycle
        step("mul_r7b",      1, 1, 1, 2, 1, 7, 1, 0, 1, 0, 0);
        step("div_wait",     1, 1, 1, 2, 1, 9, 1, 0, 1, 0, 0);
        step("div_done",     1, 1, 1, 2, 1, 9, 1, 0, 1, 0, 1);
        step("div_busy",     1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        step("div_fin",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step("waw_free",     1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0);
        // r0 never hazards; flush kills a hazardous slot
        step("add_r0",       1, 1, 1, 2, 1, 0, 1, 0, 0, 0, 0);
        step("read_r0",      1, 0, 1, 0, 1, 1, 1, 0, 0, 0, 0);
        step("lw_r5b",       1, 2, 1, 0, 0, 5, 1, 1, 0, 0, 0);
        step("flush_haz",    1, 5, 1, 5, 1, 6, 1, 0, 0, 1, 0);
        step("after_flush",  1, 6, 1, 5, 1, 2, 1, 0, 0, 0, 0);
        // Reset while a long op is pending and every stage is full
        step("mul_pre",      1, 0, 0, 0, 0, 7, 1, 0, 1, 0, 0);
        step("fill_1",       1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        step("fill_2",       1, 0, 0, 0, 0, 2, 1, 1, 0, 0, 0);
        step("fill_3",       1, 0, 0, 0, 0, 3, 1, 1, 0, 0, 0);
        do_reset();
        step("post_reset",   1, 7, 1, 3, 1, 8, 1, 0, 0, 0, 0);
        // Randomised traffic over a small register set to provoke hazards
        for (int n = 0; n < 400; n++) begin
            bit dn;
            dn = pv ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
            step("rand", $urandom_range(0, 9) != 0,
                 $urandom_range(0, 7), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 7), $urandom_range(0, 1) != 0,
                 $urandom_range(0, 7), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 9) == 0, dn);
        end
        @(negedge clock);
        @(negedge clock);
        cmp("drain", "queue_left", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised hazard and bypass controller for the in-order pipelined processor.
- Replaces ad-hoc stall logic (full stall on any in-flight destination match) with a tracked per-stage destination pipeline, operand-forward selects, load-use detection and a pending-tag scoreboard for long-latency ops (mult/div).
- Sits beside the F/D latch; consulted every cycle by decode; drives PC/FD write-enable and DX bubble insertion.

Parameters:
- REG_BITS, 5, register index width; register 0 is never a hazard.
- STAGES, 3, number of tracked stages after decode (index 0 = X, 1 = M, 2 = W).
- LOAD_READY_STAGE, 2, lowest stage index whose load data is forwardable; a load in stage index < this value forces a stall.
- SEL_W, 2, width of forward selects; must satisfy 2^SEL_W > STAGES.

Ports:
- clock, in, 1, master clock, rising edge.
- reset, in, 1, synchronous active-high reset.
- dec_valid, in, 1, decode slot holds a real instruction.
- dec_rs, in, REG_BITS, source A index.
- dec_rt, in, REG_BITS, source B index (rd for jr/store, selected upstream).
- dec_rs_used, in, 1, source A is read.
- dec_rt_used, in, 1, source B is read.
- dec_rd, in, REG_BITS, destination index.
- dec_rd_we, in, 1, instruction writes dec_rd.
- dec_is_load, in, 1, instruction is lw.
- dec_is_long, in, 1, instruction is mult/div.
- flush, in, 1, kill decode slot (taken branch/jump).
- long_done, in, 1, long unit result written this cycle (one-cycle pulse).
- stall, out, 1, hold PC and FD latch; insert bubble into DX.
- fwd_sel_a, out, SEL_W, 0 = regfile, k = forward from stage k-1.
- fwd_sel_b, out, SEL_W, same encoding for source B.
- long_busy, out, 1, long op outstanding.

Behaviour:
- State: per stage i a valid bit, tag[REG_BITS] and is_load; plus pend_valid and pend_tag.
- Reset: all stage valids 0, pend_valid 0. Outputs after reset: stall 0, fwd_sel_a 0, fwd_sel_b 0, long_busy 0.
- Entry written: dec_valid & dec_rd_we & dec_rd != 0 & !dec_is_long & !stall & !flush. Otherwise stage 0 receives a bubble (valid 0).
- Advance: stages shift every cycle, stall or not. stage[i] <= stage[i-1] for i ≥ 1; the oldest stage drops out.
- Match: src_match(s, i) = used_s & s != 0 & stage[i].valid & stage[i].tag == s.
- Forward select: the youngest (lowest i) match wins; fwd_sel = i + 1; no match gives 0.
- Outputs: stall and fwd_sel are combinational from state and current decode inputs (zero latency). long_busy = pend_valid.
- Stall, when dec_valid & !flush, is the OR of:
  - (a) load-use: the youngest match for either source is at stage i < LOAD_READY_STAGE with is_load set.
  - (b) RAW on long op: either used source equals pend_tag while pend_valid.
  - (c) WAW: dec_rd_we & dec_rd == pend_tag while pend_valid.
  - (d) structural: dec_is_long while pend_valid & !long_done.
- With flush or !dec_valid: stall = 0 and fwd_sel = 0.
- Scoreboard update:
  - long_done clears pend_valid.
  - An accepted dec_is_long (no stall, no flush) with rd != 0 sets pend_valid and pend_tag = dec_rd.
  - Same-cycle long_done and accept: the new tag wins.
- long_done while pend_valid = 0 is ignored.
- long_done does not release (b) or (c) in the same cycle; the consumer issues the following cycle.
- Reset mid-operation clears the pending tag and all stages; no stale stall after reset.

Decomposition:
- Shared package pipe_pkg:
  - REG_BITS;
  - stage index constants STG_X = 0, STG_M = 1, STG_W = 2;
  - forward-select encodings FWD_RF = 0, FWD_X = 1, FWD_M = 2, FWD_W = 3;
  - stage-entry struct {valid, tag, is_load}.
- One natural sub-module, src_match_prio: per-source priority match across STAGES, returning fwd_sel and a load-hazard bit. Instantiate it twice (A and B).

Test Plan:
- add r3 issued, next decode add r4,r3,r1 -> stall 0, fwd_sel_a = 1 (X); one cycle later same consumer gives fwd_sel_a = 2 (M).
- lw r5 then immediately add r6,r5,r5 -> stall 1 for exactly 2 cycles (X, then M) with a bubble inserted each cycle; third cycle stall 0, fwd_sel_a = fwd_sel_b = 3.
- mul r7 accepted -> long_busy 1. Subsequent add r8,r7,r0 stalls until long_done pulses; it stays stalled in the done cycle and issues the next cycle with fwd_sel_a = 0.
- mul r7 pending, then div r9 -> stall 1; long_done pulse -> same cycle div accepted, pend_tag = 9, long_busy stays 1.
- Writes and reads of r0 (add r0 then add r1,r0,r0) -> never stall, fwd_sel = 0. flush asserted with a hazardous decode -> stall 0 and a bubble enters stage X.
- Assert reset mid-sequence with pend_valid = 1 and all stages valid -> next cycle long_busy 0 and a hazardous decode reads stall 0.
